alu: RTL and testbench
======================

Name: alu

Overview:
- 8-bit registered arithmetic/logic unit for the 8-bit microprocessor datapath.
- Selects two operands from register-file outputs, the 6-bit instruction immediate, or the 6-bit program counter.
- Executes one of eight operations and registers the result together with N/Z/P condition flags for the branch logic.

Parameters:
- WIDTH, 8, datapath width. Result, register operands and flag logic scale with it.
- IMM_W, 6, width of the instruction immediate and of pc.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- alu_op  input  3  operation select (encodings under Behaviour).
- source_sel  input  3  operand-source select (encodings under Behaviour).
- ins_immediate  input  6  instruction immediate field, two's complement.
- pc  input  6  current program counter, unsigned.
- reg_sr1_out  input  8  register-file source-1 read data.
- reg_sr2_out  input  8  register-file source-2 read data.
- negative  output  1  registered flag: result bit 7 set.
- zero  output  1  registered flag: result equals 0.
- positive  output  1  registered flag: result is nonzero and bit 7 is clear.
- result  output  8  registered ALU result.

Behaviour:
- Operand selection is combinational. sext = sign-extend the 6-bit value to 8 bits; zext = zero-extend it.
- source_sel 000: A = reg_sr1_out, B = sext(ins_immediate). Used for immediate-form instructions such as addi.
- source_sel 001: A = reg_sr1_out, B = reg_sr2_out.
- source_sel 010: A = zext(pc), B = sext(ins_immediate). Used for PC-relative targets.
- source_sel 011: A = reg_sr1_out, B = zext(ins_immediate).
- source_sel 100: A = zext(pc), B = reg_sr2_out.
- source_sel 101, 110, 111: treated as 001.
- alu_op 000 ADD: A+B.
- alu_op 001 SUB: A-B.
- alu_op 010 AND.
- alu_op 011 OR.
- alu_op 100 XOR.
- alu_op 101 NOT: ~A, B ignored.
- alu_op 110 SHL: A << B[2:0], zero fill.
- alu_op 111 SHR: A >> B[2:0], logical, zero fill.
- Arithmetic is modulo 256. Carry and overflow are discarded and not reported.
- Latency is 1 cycle. Inputs sampled at rising edge k appear on result and the flags after edge k. No handshake: a new operation is accepted every cycle.
- Flags are computed from the next result value and registered in the same edge as result.
  - Exactly one of negative, zero, positive is 1 at all times.
- Reset, on a rising edge with rst=1:
  - result = 0x00, zero = 1, negative = 0, positive = 0.
  - rst overrides any operation presented in the same cycle. The first post-reset result appears one edge after rst deasserts.
- Any X-free input combination produces a defined output. There are no illegal encodings.

Decomposition:
- Shared package alu_pkg holds:
  - localparams for the alu_op encodings (OP_ADD … OP_SHR);
  - localparams for the source_sel encodings (SRC_SR1_IMM, SRC_SR1_SR2, SRC_PC_IMM, SRC_SR1_UIMM, SRC_PC_SR2);
  - the width constants.
- One sub-module, alu_operand_mux, is natural: it holds the combinational source_sel decode and the sign/zero extension.
- The top level holds the operation case, the flag logic and the output registers.

Test Plan:
- Reset: hold rst=1 for 2 edges, then release → result=0x00, zero=1, negative=0, positive=0. Next, source_sel=000, alu_op=000, sr1=0x34, imm=6'b010100 → after one edge result=0x48, positive=1.
- Immediate sign-extension and PC-relative addressing:
  - source_sel=000, ADD, sr1=0x34, imm=6'b111100 → 0x30, positive=1.
  - source_sel=010, ADD, pc=6'b011100, imm=6'b111100 → 0x18.
  - source_sel=011, same sr1 and imm as the first case → 0x70.
- Register forms:
  - source_sel=001, sr1=0x34, sr2=0x4A, SUB → 0xEA, negative=1.
  - AND → 0x00, zero=1.
  - OR → 0x7E.
  - XOR → 0x7E.
  - NOT → 0xCB, negative=1.
- Shifts and wrap:
  - SHL sr1=0x81, sr2=0x01 → 0x02.
  - SHR sr1=0x81, sr2=0x09 (amount 1) → 0x40.
  - ADD 0xFF+0x01 → 0x00, zero=1.
- Back-to-back and reset mid-stream:
  - Change alu_op every cycle → each result appears exactly one edge later.
  - Assert rst in a cycle presenting ADD 0x34+0x14 → result 0x00, zero=1, not 0x48.
- Flag exclusivity: random 1000-cycle run against a reference model → result matches and exactly one flag is set every cycle.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_pkg                                                    |
// | Description : Shared constants for the 8-bit datapath ALU: default       |
// |               widths, alu_op encodings and source_sel encodings.         |
// | Ports       : none (package)                                             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package alu_pkg;

    // Default widths; the top and operand mux take these as parameter defaults.
    localparam int ALU_WIDTH = 8;
    localparam int ALU_IMM_W = 6;

    // alu_op encodings
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    // source_sel encodings (101..111 behave as SRC_SR1_SR2)
    localparam logic [2:0] SRC_SR1_IMM  = 3'b000;
    localparam logic [2:0] SRC_SR1_SR2  = 3'b001;
    localparam logic [2:0] SRC_PC_IMM   = 3'b010;
    localparam logic [2:0] SRC_SR1_UIMM = 3'b011;
    localparam logic [2:0] SRC_PC_SR2   = 3'b100;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_operand_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_operand_mux                                            |
// | Description : Combinational operand selection for the ALU. Decodes       |
// |               source_sel and sign/zero-extends the immediate and pc.     |
// | Ports       : source_sel_i   operand-source select                       |
// |               imm_i          instruction immediate (two's complement)    |
// |               pc_i           program counter (unsigned)                  |
// |               sr1_i, sr2_i   register-file read data                     |
// |               operand_a_o    selected A operand                          |
// |               operand_b_o    selected B operand                          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module alu_operand_mux
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int IMM_W = ALU_IMM_W
) (
    input  logic [2:0]       source_sel_i,
    input  logic [IMM_W-1:0] imm_i,
    input  logic [IMM_W-1:0] pc_i,
    input  logic [WIDTH-1:0] sr1_i,
    input  logic [WIDTH-1:0] sr2_i,
    output logic [WIDTH-1:0] operand_a_o,
    output logic [WIDTH-1:0] operand_b_o
);

    logic [WIDTH-1:0] w_imm_sext;
    logic [WIDTH-1:0] w_imm_zext;
    logic [WIDTH-1:0] w_pc_zext;

    assign w_imm_sext = {{(WIDTH-IMM_W){imm_i[IMM_W-1]}}, imm_i};
    assign w_imm_zext = {{(WIDTH-IMM_W){1'b0}}, imm_i};
    assign w_pc_zext  = {{(WIDTH-IMM_W){1'b0}}, pc_i};

    always_comb begin
        // Unused encodings fall back to the register-register form.
        operand_a_o = sr1_i;
        operand_b_o = sr2_i;
        case (source_sel_i)
            SRC_SR1_IMM: begin
                operand_a_o = sr1_i;
                operand_b_o = w_imm_sext;
            end
            SRC_PC_IMM: begin
                operand_a_o = w_pc_zext;
                operand_b_o = w_imm_sext;
            end
            SRC_SR1_UIMM: begin
                operand_a_o = sr1_i;
                operand_b_o = w_imm_zext;
            end
            SRC_PC_SR2: begin
                operand_a_o = w_pc_zext;
                operand_b_o = sr2_i;
            end
            default: begin
                operand_a_o = sr1_i;
                operand_b_o = sr2_i;
            end
        endcase
    end

endmodule : alu_operand_mux
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu                                                        |
// | Description : Registered arithmetic/logic unit with N/Z/P flags for the  |
// |               8-bit microprocessor datapath. One-cycle latency, accepts  |
// |               a new operation every cycle.                               |
// | Ports       : clk, rst       clock, synchronous active-high reset        |
// |               alu_op         operation select                            |
// |               source_sel     operand-source select                       |
// |               ins_immediate  instruction immediate                       |
// |               pc             program counter                             |
// |               reg_sr1_out    register-file source-1 data                 |
// |               reg_sr2_out    register-file source-2 data                 |
// |               negative/zero/positive  registered condition flags         |
// |               result         registered result                           |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int IMM_W = ALU_IMM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       alu_op,
    input  logic [2:0]       source_sel,
    input  logic [IMM_W-1:0] ins_immediate,
    input  logic [IMM_W-1:0] pc,
    input  logic [WIDTH-1:0] reg_sr1_out,
    input  logic [WIDTH-1:0] reg_sr2_out,
    output logic             negative,
    output logic             zero,
    output logic             positive,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] w_operand_a;
    logic [WIDTH-1:0] w_operand_b;
    logic [WIDTH-1:0] w_result_d;
    logic             w_negative_d;
    logic             w_zero_d;
    logic             w_positive_d;

    logic [WIDTH-1:0] r_result_q;
    logic             r_negative_q;
    logic             r_zero_q;
    logic             r_positive_q;

    alu_operand_mux #(
        .WIDTH (WIDTH),
        .IMM_W (IMM_W)
    ) u_operand_mux (
        .source_sel_i (source_sel),
        .imm_i        (ins_immediate),
        .pc_i         (pc),
        .sr1_i        (reg_sr1_out),
        .sr2_i        (reg_sr2_out),
        .operand_a_o  (w_operand_a),
        .operand_b_o  (w_operand_b)
    );

    // Shift amount is always B[2:0]; upper B bits are ignored for shifts.
    always_comb begin
        w_result_d = '0;
        case (alu_op)
            OP_ADD: w_result_d = w_operand_a + w_operand_b;
            OP_SUB: w_result_d = w_operand_a - w_operand_b;
            OP_AND: w_result_d = w_operand_a & w_operand_b;
            OP_OR:  w_result_d = w_operand_a | w_operand_b;
            OP_XOR: w_result_d = w_operand_a ^ w_operand_b;
            OP_NOT: w_result_d = ~w_operand_a;
            OP_SHL: w_result_d = w_operand_a << w_operand_b[2:0];
            OP_SHR: w_result_d = w_operand_a >> w_operand_b[2:0];
            default: w_result_d = '0;
        endcase
    end

    // Flags derive from the next result so they register alongside it;
    // exactly one is set by construction.
    assign w_negative_d = w_result_d[WIDTH-1];
    assign w_zero_d     = (w_result_d == '0);
    assign w_positive_d = ~w_negative_d & ~w_zero_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result_q   <= '0;
            r_negative_q <= 1'b0;
            r_zero_q     <= 1'b1;
            r_positive_q <= 1'b0;
        end else begin
            r_result_q   <= w_result_d;
            r_negative_q <= w_negative_d;
            r_zero_q     <= w_zero_d;
            r_positive_q <= w_positive_d;
        end
    end

    assign result   = r_result_q;
    assign negative = r_negative_q;
    assign zero     = r_zero_q;
    assign positive = r_positive_q;

endmodule : alu
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_alu                                                     |
// | Description : Self-checking bench for alu: directed cases plus a random  |
// |               run compared against an arithmetic reference model.        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_alu;

    logic       clk;
    logic       rst;
    logic [2:0] alu_op;
    logic [2:0] source_sel;
    logic [5:0] ins_immediate;
    logic [5:0] pc;
    logic [7:0] reg_sr1_out;
    logic [7:0] reg_sr2_out;
    logic       negative;
    logic       zero;
    logic       positive;
    logic [7:0] result;

    int errors = 0;
    int checks = 0;

    alu dut (
        .clk           (clk),
        .rst           (rst),
        .alu_op        (alu_op),
        .source_sel    (source_sel),
        .ins_immediate (ins_immediate),
        .pc            (pc),
        .reg_sr1_out   (reg_sr1_out),
        .reg_sr2_out   (reg_sr2_out),
        .negative      (negative),
        .zero          (zero),
        .positive      (positive),
        .result        (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic from the operation rules.
    function automatic int model(input int op, input int sel, input int sr1,
                                 input int sr2, input int imm, input int pcv);
        int a;
        int b;
        int simm;
        int sh;
        int r;
        simm = (imm >= 32) ? imm - 64 : imm;
        case (sel)
            0:       begin a = sr1; b = simm; end
            2:       begin a = pcv; b = simm; end
            3:       begin a = sr1; b = imm;  end
            4:       begin a = pcv; b = sr2;  end
            default: begin a = sr1; b = sr2;  end
        endcase
        b  = ((b % 256) + 256) % 256;
        sh = b % 8;
        case (op)
            0:       r = a + b;
            1:       r = a - b + 256;
            2:       r = a & b;
            3:       r = a | b;
            4:       r = a ^ b;
            5:       r = 255 - a;
            6:       r = a * (1 << sh);
            default: r = a / (1 << sh);
        endcase
        return r % 256;
    endfunction

    task automatic drive(input int op, input int sel, input int sr1,
                         input int sr2, input int imm, input int pcv);
        alu_op        = op[2:0];
        source_sel    = sel[2:0];
        reg_sr1_out   = sr1[7:0];
        reg_sr2_out   = sr2[7:0];
        ins_immediate = imm[5:0];
        pc            = pcv[5:0];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int exp);
        logic [7:0] exp_r;
        logic [2:0] exp_f;
        logic [2:0] obs_f;
        exp_r = exp[7:0];
        exp_f = {(exp >= 128), (exp == 0), (exp > 0 && exp < 128)};
        obs_f = {negative, zero, positive};
        checks++;
        assert (result === exp_r) else begin
            errors++;
            $error("FAIL %s result: observed=%02h expected=%02h", tag, result, exp_r);
        end
        checks++;
        assert (obs_f === exp_f) else begin
            errors++;
            $error("FAIL %s flags(NZP): observed=%03b expected=%03b", tag, obs_f, exp_f);
        end
        checks++;
        assert ($countones(obs_f) === 1) else begin
            errors++;
            $error("FAIL %s onehot: observed=%03b expected exactly one flag", tag, obs_f);
        end
    endtask

    initial begin
        int exp;
        rst = 1'b1;
        drive(0, 0, 8'h34, 0, 6'b010100, 0);

        // Reset held for two edges
        step();
        step();
        check("reset", 8'h00);

        // First post-reset operation
        rst = 1'b0;
        step();
        check("addi_pos", 8'h48);

        // Sign/zero extension and PC-relative
        drive(0, 0, 8'h34, 0, 6'b111100, 0);
        step();
        check("addi_neg", 8'h30);
        drive(0, 2, 0, 0, 6'b111100, 6'b011100);
        step();
        check("pc_rel", 8'h18);
        drive(0, 3, 8'h34, 0, 6'b111100, 0);
        step();
        check("uimm", 8'h70);

        // Register forms
        drive(1, 1, 8'h34, 8'h4A, 0, 0); step(); check("sub", 8'hEA);
        drive(2, 1, 8'h34, 8'h4A, 0, 0); step(); check("and", 8'h00);
        drive(3, 1, 8'h34, 8'h4A, 0, 0); step(); check("or",  8'h7E);
        drive(4, 1, 8'h34, 8'h4A, 0, 0); step(); check("xor", 8'h7E);
        drive(5, 1, 8'h34, 8'h4A, 0, 0); step(); check("not", 8'hCB);

        // Shifts and wrap
        drive(6, 1, 8'h81, 8'h01, 0, 0); step(); check("shl", 8'h02);
        drive(7, 1, 8'h81, 8'h09, 0, 0); step(); check("shr", 8'h40);
        drive(0, 1, 8'hFF, 8'h01, 0, 0); step(); check("wrap", 8'h00);

        // PC + sr2 and an unused source_sel encoding
        drive(0, 4, 0, 8'h80, 0, 6'h3F); step(); check("pc_sr2", 8'hBF);
        drive(1, 6, 8'h10, 8'h20, 6'h3F, 6'h3F); step(); check("sel_110", 8'hF0);

        // Back-to-back: new op every cycle, each result one edge later
        for (int op = 0; op < 8; op++) begin
            drive(op, 1, 8'hC5, 8'h3B, 0, 0);
            exp = model(op, 1, 8'hC5, 8'h3B, 0, 0);
            step();
            check($sformatf("b2b_op%0d", op), exp);
        end

        // Reset mid-stream overrides a presented ADD
        rst = 1'b1;
        drive(0, 0, 8'h34, 0, 6'b010100, 0);
        step();
        check("rst_mid", 8'h00);
        rst = 1'b0;
        step();
        check("post_rst", 8'h48);

        // Random run against the reference model
        for (int i = 0; i < 1000; i++) begin
            int op, sel, sr1, sr2, imm, pcv;
            op  = $urandom_range(0, 7);
            sel = $urandom_range(0, 7);
            sr1 = $urandom_range(0, 255);
            sr2 = $urandom_range(0, 255);
            imm = $urandom_range(0, 63);
            pcv = $urandom_range(0, 63);
            rst = ($urandom_range(0, 49) == 0);
            drive(op, sel, sr1, sr2, imm, pcv);
            exp = rst ? 0 : model(op, sel, sr1, sr2, imm, pcv);
            step();
            check($sformatf("rand%0d_op%0d_sel%0d", i, op, sel), exp);
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_alu
`default_nettype wire
